// File: rtl/led_pkg.sv
// Shared constants for the LED status block: channel mode encodings,
// code-blink FSM state encodings and a small drive-level helper.
package led_pkg;

    // Channel mode encodings, two bits per channel on the mode bus
    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_ON    = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;
    localparam logic [1:0] MODE_CODE  = 2'b11;

    // Code-blink FSM states
    localparam logic [1:0] ST_IDLE      = 2'b00;
    localparam logic [1:0] ST_PULSE_ON  = 2'b01;
    localparam logic [1:0] ST_PULSE_OFF = 2'b10;
    localparam logic [1:0] ST_GAP       = 2'b11;

    // Map a logical "lit" flag onto the board's LED active level
    function automatic logic drive_level(input logic lit_s, input logic act_s);
        return lit_s ? act_s : ~act_s;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Base-tick prescaler shared by every LED channel. The counter runs
// 0..L_TIME-1 and the registered tick is high exactly while it reads L_TIME-1.
module led_tick_gen #(
    parameter int unsigned L_TIME = 32'd25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned CNT_W = (L_TIME > 32'd1) ? $clog2(L_TIME) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(L_TIME - 32'd1);
    // tick is registered, so it is set one count early to line up with CNT_LAST
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(L_TIME - 32'd2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

    logic [CNT_W-1:0] cnt_r;
    logic             tick_r;

    // Wrapping prescaler count and the registered tick strobe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else begin
            if (cnt_r == CNT_LAST) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
            tick_r <= (cnt_r == CNT_PRE);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/led_status.sv
// Multi-channel LED status driver: off / steady / blink / blink-code per
// channel, all phased from one shared base tick.
module led_status
    import led_pkg::*;
#(
    parameter int unsigned LED_NUM   = 32'd4,
    parameter int unsigned L_TIME    = 32'd25_000_000,
    parameter int unsigned CODE_W    = 32'd3,
    parameter int unsigned GAP_TICKS = 32'd4,
    parameter logic        LED_ACT   = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [2*LED_NUM-1:0]        mode,
    input  logic [CODE_W*LED_NUM-1:0]   code,
    output logic [LED_NUM-1:0]          led,
    output logic                        tick
);

    localparam int unsigned GAP_W = $clog2(GAP_TICKS + 32'd1);
    localparam logic [CODE_W-1:0] PCNT_ONE = CODE_W'(32'd1);
    localparam logic [GAP_W-1:0]  GCNT_ONE = GAP_W'(32'd1);
    localparam logic [GAP_W-1:0]  GCNT_END = GAP_W'(GAP_TICKS);

    logic tick_s;

    led_tick_gen #(
        .L_TIME (L_TIME)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick_s)
    );

    assign tick = tick_s;

    for (genvar i = 0; i < LED_NUM; i++) begin : g_ch
        logic [1:0]        mode_s;
        logic [CODE_W-1:0] code_s;
        logic [1:0]        mode_r;
        logic [CODE_W-1:0] code_r;
        logic [1:0]        state_r;
        logic [1:0]        state_nxt_s;
        logic [CODE_W-1:0] pcnt_r;
        logic [CODE_W-1:0] pcnt_nxt_s;
        logic [GAP_W-1:0]  gcnt_r;
        logic [GAP_W-1:0]  gcnt_nxt_s;
        logic              led_r;
        logic              lit_s;
        logic              lit_nxt_s;
        logic              chg_s;

        assign mode_s = mode[2*i +: 2];
        assign code_s = code[CODE_W*i +: CODE_W];
        assign lit_s  = (led_r == LED_ACT);
        // Any difference from the stored copy restarts the channel; the
        // restart outranks a coincident tick.
        assign chg_s  = (mode_s != mode_r) || (code_s != code_r);

        // Next-state logic for one channel: mode decode plus code-blink FSM
        always_comb begin
            state_nxt_s = state_r;
            pcnt_nxt_s  = pcnt_r;
            gcnt_nxt_s  = gcnt_r;
            lit_nxt_s   = lit_s;
            case (mode_s)
                MODE_OFF: begin
                    state_nxt_s = ST_IDLE;
                    pcnt_nxt_s  = '0;
                    gcnt_nxt_s  = '0;
                    lit_nxt_s   = 1'b0;
                end
                MODE_ON: begin
                    state_nxt_s = ST_IDLE;
                    pcnt_nxt_s  = '0;
                    gcnt_nxt_s  = '0;
                    lit_nxt_s   = 1'b1;
                end
                MODE_BLINK: begin
                    state_nxt_s = ST_IDLE;
                    pcnt_nxt_s  = '0;
                    gcnt_nxt_s  = '0;
                    if (chg_s) begin
                        lit_nxt_s = 1'b1;
                    end else if (tick_s) begin
                        lit_nxt_s = ~lit_s;
                    end else begin
                        lit_nxt_s = lit_s;
                    end
                end
                MODE_CODE: begin
                    if (code_s == '0) begin
                        state_nxt_s = ST_IDLE;
                        pcnt_nxt_s  = '0;
                        gcnt_nxt_s  = '0;
                        lit_nxt_s   = 1'b0;
                    end else if (chg_s) begin
                        state_nxt_s = ST_PULSE_ON;
                        pcnt_nxt_s  = PCNT_ONE;
                        gcnt_nxt_s  = '0;
                        lit_nxt_s   = 1'b1;
                    end else if (tick_s) begin
                        case (state_r)
                            ST_PULSE_ON: begin
                                state_nxt_s = ST_PULSE_OFF;
                                lit_nxt_s   = 1'b0;
                            end
                            ST_PULSE_OFF: begin
                                if (pcnt_r == code_s) begin
                                    state_nxt_s = ST_GAP;
                                    gcnt_nxt_s  = GCNT_ONE;
                                    lit_nxt_s   = 1'b0;
                                end else begin
                                    state_nxt_s = ST_PULSE_ON;
                                    pcnt_nxt_s  = pcnt_r + PCNT_ONE;
                                    lit_nxt_s   = 1'b1;
                                end
                            end
                            ST_GAP: begin
                                if (gcnt_r == GCNT_END) begin
                                    state_nxt_s = ST_PULSE_ON;
                                    pcnt_nxt_s  = PCNT_ONE;
                                    gcnt_nxt_s  = '0;
                                    lit_nxt_s   = 1'b1;
                                end else begin
                                    gcnt_nxt_s  = gcnt_r + GCNT_ONE;
                                    lit_nxt_s   = 1'b0;
                                end
                            end
                            default: begin
                                // Stray IDLE with a live code: resynchronise at a pulse start
                                state_nxt_s = ST_PULSE_ON;
                                pcnt_nxt_s  = PCNT_ONE;
                                gcnt_nxt_s  = '0;
                                lit_nxt_s   = 1'b1;
                            end
                        endcase
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    pcnt_nxt_s  = '0;
                    gcnt_nxt_s  = '0;
                    lit_nxt_s   = 1'b0;
                end
            endcase
        end

        // Channel registers: stored inputs, FSM, counters and LED drive
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                mode_r  <= '0;
                code_r  <= '0;
                state_r <= ST_IDLE;
                pcnt_r  <= '0;
                gcnt_r  <= '0;
                led_r   <= ~LED_ACT;
            end else begin
                mode_r  <= mode_s;
                code_r  <= code_s;
                state_r <= state_nxt_s;
                pcnt_r  <= pcnt_nxt_s;
                gcnt_r  <= gcnt_nxt_s;
                led_r   <= drive_level(lit_nxt_s, LED_ACT);
            end
        end

        assign led[i] = led_r;
    end

endmodule

// File: doc/led_status.md
LED_STATUS -- requirements
Module: led_status

Interface
REQ-001 Parameter LED_NUM, default 4, number of independent LED channels (1..8).
REQ-002 Parameter L_TIME, default 25'd25_000_000, clocks per base tick (500 ms at 50 MHz); minimum 2.
REQ-003 Parameter CODE_W, default 3, width of each channel's blink-code count.
REQ-004 Parameter GAP_TICKS, default 4, ticks of dark gap after each code sequence; minimum 1.
REQ-005 Parameter LED_ACT, default 1'b1, LED active level.
REQ-006 clk  input  1  system clock; single clock domain.
REQ-007 rst_n  input  1  reset, synchronous, active-low.
REQ-008 mode  input  2*LED_NUM  per-channel mode, channel i at [2i+1:2i]: 00 off, 01 steady on, 10 blink, 11 code-blink.
REQ-009 code  input  CODE_W*LED_NUM  per-channel pulse count for code-blink, channel i at [CODE_W*i+CODE_W-1:CODE_W*i].
REQ-010 led  output  LED_NUM  registered LED drive, bit i = channel i.
REQ-011 tick  output  1  single-cycle base-tick strobe, for debug and system use.

Function
REQ-012 Tick counter SHALL count 0..L_TIME-1 and wrap; tick SHALL be high for exactly the one cycle in which the counter equals L_TIME-1.
REQ-013 One tick generator SHALL be shared by all channels; channels SHALL NOT own private prescalers.
REQ-014 Each channel SHALL hold the registered copy of its previous mode and code; a change of either SHALL restart that channel in the cycle the change is sampled.
REQ-015 Mode 00: led[i] SHALL be inactive (~LED_ACT) from the cycle after mode is sampled.
REQ-016 Mode 01: led[i] SHALL be LED_ACT from the cycle after mode is sampled.
REQ-017 Mode 10: led[i] SHALL go active on entry and toggle on every tick after that; the blink phase SHALL follow the shared tick, not the entry time.
REQ-018 Mode 11: the per-channel FSM SHALL use the states IDLE, PULSE_ON, PULSE_OFF and GAP.
REQ-019 On entry to mode 11 with code != 0: state PULSE_ON, led active, pulse count = 1.
REQ-020 PULSE_ON SHALL go to PULSE_OFF on tick, with led inactive.
REQ-021 PULSE_OFF on tick: if pulse count == code, go to GAP with gap count = 1; otherwise increment pulse count and return to PULSE_ON.
REQ-022 GAP on tick: if gap count == GAP_TICKS, go to PULSE_ON with pulse count = 1; otherwise increment gap count; led SHALL stay inactive throughout GAP.
REQ-023 Mode 11 with code == 0: FSM SHALL stay in IDLE and led SHALL be inactive.
REQ-024 Pulse counter SHALL be CODE_W bits and gap counter SHALL be clog2(GAP_TICKS+1) bits; neither SHALL wrap within a valid sequence.
REQ-025 A mode or code change on the same cycle as tick: the restart SHALL take priority and that tick SHALL be ignored for that channel.
REQ-026 In modes other than 11, the FSM SHALL be held in IDLE.
REQ-027 Channels SHALL be fully independent; a change on one channel SHALL NOT disturb the state of any other channel.

Reset
REQ-028 While rst_n is low at a clk edge: tick counter = 0, tick = 0, all led = ~LED_ACT, all FSMs = IDLE, all pulse and gap counters = 0, all stored mode/code = 0.
REQ-029 After reset is released, mode and code inputs that are already nonzero SHALL be treated as a change and take effect one cycle later.
REQ-030 Reset asserted mid-sequence SHALL abandon the sequence; no partial pulse SHALL resume after release.

Structure
REQ-031 The mode encodings (OFF, ON, BLINK, CODE) and the FSM state encodings SHALL be constants in the shared package led_pkg.
REQ-032 The tick prescaler SHALL be a sub-module, led_tick_gen, parametrised by L_TIME.
REQ-033 Per-channel logic SHALL be a generate loop inside led_status, not a separate module.

Verification (L_TIME=4, GAP_TICKS=2, CODE_W=3, LED_NUM=4)
REQ-034 Reset: rst_n low 3 cycles with mode=8'hFF -> led=4'b0000 and tick=0 throughout; tick first pulses 4 cycles after release.
REQ-035 Steady/off: mode=8'h01 -> led=4'b0001 one cycle later; mode=8'h00 -> led=4'b0000 one cycle later.
REQ-036 Blink: ch1 mode=10 -> led[1]=1, then toggles every 4 cycles, aligned to tick, for at least 5 toggles.
REQ-037 Code: ch2 mode=11, code=3 -> led[2] pattern in ticks ON,OFF,ON,OFF,ON,OFF,GAP,GAP, repeating twice.
REQ-038 Restart and collision: change ch2 code 3->2 in the same cycle as tick, mid-PULSE_OFF -> restart at PULSE_ON with count 1, tick ignored; ch3 set to mode=11, code=0 -> led[3]=0 and FSM stays IDLE.
REQ-039 Reset mid-sequence: rst_n low during ch2 GAP -> all outputs return to reset values; after release the sequence restarts from PULSE_ON.
